count_ctrl: RTL and testbench

- Front-end control stage for the 4-bit reversible counter.
- Converts two raw push-buttons (up, down) into the counter's count-enable pulse (CE) and count-direction level (CD).
- Provides synchronisation, debouncing, single-step on press and auto-repeat on hold.
- CE and CD connect directly to the counter's CE/CD inputs; the counter's clock is this block's CLK.

---
 rtl/count_ctrl_if.sv | 24 ++
 rtl/count_ctrl.sv | 160 ++++++++++++++++
 tb/tb_count_ctrl.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/count_ctrl_if.sv
// Button-to-counter control bus: raw push-buttons in, counter enable/direction out.
interface count_ctrl_if;
  logic btn_up;
  logic btn_dn;
  logic ce;
  logic cd;
  logic hold;

  modport master (
    output btn_up,
    output btn_dn,
    input  ce,
    input  cd,
    input  hold
  );

  modport slave (
    input  btn_up,
    input  btn_dn,
    output ce,
    output cd,
    output hold
  );
endinterface

// File: rtl/count_ctrl.sv
// Push-button front end for the reversible counter: synchronise, debounce,
// single step on press and auto-repeat while held.
module count_ctrl #(
  parameter int DEB_CYCLES    = 4,
  parameter int REPEAT_DELAY  = 20,
  parameter int REPEAT_PERIOD = 8
) (
  input  logic         clk,
  input  logic         rst,
  count_ctrl_if.slave  bus
);

  localparam int DW   = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam int TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TW   = $clog2(TMAX);

  localparam logic [DW-1:0] DEB_LAST    = DW'(DEB_CYCLES - 1);
  localparam logic [TW-1:0] DELAY_LAST  = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] PERIOD_LAST = TW'(REPEAT_PERIOD - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DELAY  = 2'd1;
  localparam logic [1:0] REPEAT = 2'd2;
  localparam logic [1:0] LOCK   = 2'd3;

  // Index 0 is the up button, index 1 the down button.
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    deb;
  logic [DW-1:0] deb_cnt [2];

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_nxt;
  logic          ce_q;
  logic          ce_nxt;
  logic          cd_q;
  logic          cd_nxt;
  logic          hold_q;

  logic up;
  logic dn;
  logic active;
  logic opposite;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      for (int i = 0; i < 2; i++) begin
        deb_cnt[i] <= '0;
      end
    end else begin
      sync1 <= {bus.btn_dn, bus.btn_up};
      sync2 <= sync1;
      // A change is accepted only after DEB_CYCLES consecutive disagreeing cycles.
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          deb[i]     <= ~deb[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign up       = deb[0];
  assign dn       = deb[1];
  assign active   = cd_q ? dn : up;
  assign opposite = cd_q ? up : dn;

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    ce_nxt    = 1'b0;
    cd_nxt    = cd_q;
    case (state)
      IDLE: begin
        if (up && !dn) begin
          ce_nxt    = 1'b1;
          cd_nxt    = 1'b0;
          timer_nxt = '0;
          state_nxt = DELAY;
        end else if (dn && !up) begin
          ce_nxt    = 1'b1;
          cd_nxt    = 1'b1;
          timer_nxt = '0;
          state_nxt = DELAY;
        end else if (up && dn) begin
          state_nxt = LOCK;
        end
      end
      DELAY: begin
        if (!active) begin
          timer_nxt = '0;
          state_nxt = IDLE;
        end else if (opposite) begin
          timer_nxt = '0;
          state_nxt = LOCK;
        end else if (timer == DELAY_LAST) begin
          ce_nxt    = 1'b1;
          timer_nxt = '0;
          state_nxt = REPEAT;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
      REPEAT: begin
        if (!active) begin
          timer_nxt = '0;
          state_nxt = IDLE;
        end else if (opposite) begin
          timer_nxt = '0;
          state_nxt = LOCK;
        end else if (timer == PERIOD_LAST) begin
          ce_nxt    = 1'b1;
          timer_nxt = '0;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
      LOCK: begin
        // Both buttons must be seen released before any new step is allowed.
        if (!up && !dn) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        timer_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      timer  <= '0;
      ce_q   <= 1'b0;
      cd_q   <= 1'b0;
      hold_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      timer  <= timer_nxt;
      ce_q   <= ce_nxt;
      cd_q   <= cd_nxt;
      hold_q <= (state_nxt == REPEAT);
    end
  end

  assign bus.ce   = ce_q;
  assign bus.cd   = cd_q;
  assign bus.hold = hold_q;

endmodule

// File: tb/tb_count_ctrl.sv
// Directed bench for count_ctrl: tap, hold/auto-repeat, glitch rejection,
// simultaneous-press lockout and reset during repeat.
module tb_count_ctrl;

  localparam int DEB  = 4;
  localparam int RD   = 20;
  localparam int RP   = 8;
  localparam int LAT  = DEB + 3;

  logic clk;
  logic rst;

  count_ctrl_if bus ();

  count_ctrl #(
    .DEB_CYCLES    (DEB),
    .REPEAT_DELAY  (RD),
    .REPEAT_PERIOD (RP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  int   edge_no;
  int   double_ce = 0;
  logic prev_ce;
  int   pulse_edge[$];
  int   pulse_cd[$];
  int   hold_cnt;
  int   hold_first;
  int   hold_last;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic clearStats();
    edge_no    = 0;
    pulse_edge.delete();
    pulse_cd.delete();
    hold_cnt   = 0;
    hold_first = -1;
    hold_last  = -1;
    prev_ce    = bus.ce;
  endtask

  // One clock edge; outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    edge_no++;
    if (bus.ce) begin
      pulse_edge.push_back(edge_no);
      pulse_cd.push_back(int'(bus.cd));
      if (prev_ce) double_ce++;
    end
    if (bus.hold) begin
      if (hold_cnt == 0) hold_first = edge_no;
      hold_last = edge_no;
      hold_cnt++;
    end
    prev_ce = bus.ce;
  endtask

  task automatic applyStimulus(input logic up, input logic dn, input int n);
    bus.btn_up = up;
    bus.btn_dn = dn;
    repeat (n) step();
  endtask

  // Pulse k of a held press lands at LAT, then LAT+RD, then every RP after that.
  task automatic checkPulses(input string tag, input int n, input int exp_cd);
    int exp_edge;
    checkOutput({tag, "_count"}, pulse_edge.size(), n);
    for (int k = 0; k < n && k < pulse_edge.size(); k++) begin
      if (k == 0) exp_edge = LAT;
      else        exp_edge = LAT + RD + (k - 1) * RP;
      checkOutput($sformatf("%s_edge%0d", tag, k), pulse_edge[k], exp_edge);
      checkOutput($sformatf("%s_cd%0d", tag, k), pulse_cd[k], exp_cd);
    end
  endtask

  initial begin
    rst        = 1'b1;
    bus.btn_up = 1'b0;
    bus.btn_dn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_ce", int'(bus.ce), 0);
    checkOutput("reset_cd", int'(bus.cd), 0);
    checkOutput("reset_hold", int'(bus.hold), 0);
    rst = 1'b0;

    // Idle with no buttons.
    clearStats();
    applyStimulus(1'b0, 1'b0, 100);
    checkPulses("idle", 0, 0);
    checkOutput("idle_hold", hold_cnt, 0);
    checkOutput("idle_cd", int'(bus.cd), 0);

    // Short press: one step, no repeat, nothing on release.
    clearStats();
    applyStimulus(1'b1, 1'b0, 15);
    applyStimulus(1'b0, 1'b0, 20);
    checkPulses("up_tap", 1, 0);
    checkOutput("up_tap_hold", hold_cnt, 0);

    // Held down button: release sampled at edge 101 is accepted at edge 106,
    // the FSM leaves REPEAT at edge 107, so the last pulse is at edge 99.
    clearStats();
    applyStimulus(1'b0, 1'b1, 100);
    applyStimulus(1'b0, 1'b0, 20);
    checkPulses("dn_hold", 11, 1);
    checkOutput("dn_hold_first", hold_first, LAT + RD);
    checkOutput("dn_hold_last", hold_last, 106);
    checkOutput("dn_hold_cnt", hold_cnt, 106 - (LAT + RD) + 1);
    checkOutput("dn_hold_cd_after", int'(bus.cd), 1);

    // Glitches of 1..3 cycles are rejected; a steady press then steps once.
    clearStats();
    for (int i = 0; i < 50; i++) begin
      applyStimulus(1'b1, 1'b0, (i % 3) + 1);
      applyStimulus(1'b0, 1'b0, 4);
    end
    checkOutput("glitch_pulses", pulse_edge.size(), 0);
    clearStats();
    applyStimulus(1'b1, 1'b0, 15);
    applyStimulus(1'b0, 1'b0, 20);
    checkPulses("post_glitch", 1, 0);

    // Simultaneous press locks out until both are released.
    clearStats();
    applyStimulus(1'b1, 1'b1, 15);
    checkOutput("lock_both", pulse_edge.size(), 0);
    applyStimulus(1'b0, 1'b1, 15);
    checkOutput("lock_dn_only", pulse_edge.size(), 0);
    applyStimulus(1'b0, 1'b0, 15);
    checkOutput("lock_released", pulse_edge.size(), 0);
    checkOutput("lock_hold", hold_cnt, 0);
    clearStats();
    applyStimulus(1'b1, 1'b0, 15);
    applyStimulus(1'b0, 1'b0, 20);
    checkPulses("unlock_up", 1, 0);

    // Reset while auto-repeating down, then restart with up held.
    clearStats();
    applyStimulus(1'b0, 1'b1, 45);
    checkPulses("rep_pre", 4, 1);
    checkOutput("rep_pre_hold", int'(bus.hold), 1);
    rst = 1'b1;
    step();
    checkOutput("rep_rst_ce", int'(bus.ce), 0);
    checkOutput("rep_rst_hold", int'(bus.hold), 0);
    checkOutput("rep_rst_cd", int'(bus.cd), 0);
    bus.btn_up = 1'b1;
    bus.btn_dn = 1'b0;
    step();
    rst = 1'b0;
    clearStats();
    applyStimulus(1'b1, 1'b0, 12);
    checkPulses("post_rst", 1, 0);
    applyStimulus(1'b0, 1'b0, 20);

    checkOutput("no_double_ce", double_ce, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
